// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
//   - op encodings as presented on the op input
//   - FSM state type and state constants
//   - LO value written on divide by zero
package mdu_pkg;

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_MULT  = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t CALC = 2'd1;
    localparam state_t FIN  = 2'd2;

    // Wide enough for any supported WIDTH; users take the low WIDTH bits.
    localparam logic [63:0] DIV0_LO = '1;

endpackage

// File: rtl/mul_div_unit_if.sv
// Bus between the pipeline controller and the multiply/divide unit.
//   start/op/operand_a/operand_b : operation request (sampled in IDLE)
//   mthi/mtlo/mt_data            : direct HI/LO writes (IDLE only)
//   busy/done                    : handshake back to the controller
//   hi/lo                        : architectural HI/LO registers
// master = controller side, slave = mul_div_unit side.
interface mul_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic             mthi;
    logic             mtlo;
    logic [WIDTH-1:0] mt_data;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, operand_a, operand_b, mthi, mtlo, mt_data,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, operand_a, operand_b, mthi, mtlo, mt_data,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mdu_sign_fix.sv
// Conditional two's-complement negation.
//   val_i : input value
//   neg_i : 1 = output -val_i, 0 = pass through
//   val_o : result
module mdu_sign_fix #(
    parameter int W = 32
) (
    input  logic [W-1:0] val_i,
    input  logic         neg_i,
    output logic [W-1:0] val_o
);
    assign val_o = neg_i ? (~val_i + W'(1)) : val_i;
endmodule

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit holding the HI/LO registers.
//   clk   : rising-edge clock
//   reset : synchronous active-high reset, dominates everything
//   bus   : mul_div_unit_if slave (start/op/operands, mthi/mtlo, busy/done, hi/lo)
// One multiplier bit (shift-add) or one quotient bit (restoring) per CALC
// cycle on operand magnitudes; signs are re-applied when HI/LO are written.
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            reset,
    mul_div_unit_if.slave   bus
);
    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 is_div_q, is_div_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;     // {partial product | remainder, multiplier | quotient}
    logic [WIDTH-1:0]     b_q, b_d;         // multiplicand or divisor magnitude
    logic [WIDTH-1:0]     a_raw_q, a_raw_d; // raw dividend, returned in HI on divide by zero
    logic                 sign_lo_q, sign_lo_d;
    logic                 sign_hi_q, sign_hi_d;
    logic                 bzero_q, bzero_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic                 a_neg, b_neg;
    logic [WIDTH-1:0]     abs_a, abs_b;
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;
    logic [WIDTH:0]       div_sh, div_diff;
    logic [2*WIDTH-1:0]   div_next;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quo_fix, rem_fix;

    // op[0] marks the signed variants.
    assign a_neg = bus.op[0] & bus.operand_a[WIDTH-1];
    assign b_neg = bus.op[0] & bus.operand_b[WIDTH-1];

    mdu_sign_fix #(.W(WIDTH))   u_abs_a (.val_i(bus.operand_a), .neg_i(a_neg), .val_o(abs_a));
    mdu_sign_fix #(.W(WIDTH))   u_abs_b (.val_i(bus.operand_b), .neg_i(b_neg), .val_o(abs_b));
    mdu_sign_fix #(.W(2*WIDTH)) u_prod  (.val_i(acc_q), .neg_i(sign_lo_q), .val_o(prod_fix));
    mdu_sign_fix #(.W(WIDTH))   u_quo   (.val_i(acc_q[WIDTH-1:0]), .neg_i(sign_lo_q), .val_o(quo_fix));
    mdu_sign_fix #(.W(WIDTH))   u_rem   (.val_i(acc_q[2*WIDTH-1:WIDTH]), .neg_i(sign_hi_q), .val_o(rem_fix));

    // Shift-add step: add multiplicand to upper half when the current
    // multiplier LSB is set, then shift the whole accumulator right.
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? b_q : '0)};
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // Restoring step: shift the next dividend bit into the remainder and
    // subtract the divisor; a clear borrow bit means the subtraction stands.
    assign div_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign div_diff = div_sh - {1'b0, b_q};
    assign div_next = !div_diff[WIDTH]
                    ? {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1}
                    : {div_sh[WIDTH-1:0],   acc_q[WIDTH-2:0], 1'b0};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        acc_d     = acc_q;
        b_d       = b_q;
        a_raw_d   = a_raw_q;
        sign_lo_d = sign_lo_q;
        sign_hi_d = sign_hi_q;
        bzero_d   = bzero_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d   = CALC;
                    busy_d    = 1'b1;
                    cnt_d     = '0;
                    is_div_d  = bus.op[1];
                    acc_d     = {{WIDTH{1'b0}}, abs_a};
                    b_d       = abs_b;
                    a_raw_d   = bus.operand_a;
                    sign_lo_d = a_neg ^ b_neg;
                    sign_hi_d = a_neg;
                    bzero_d   = (bus.operand_b == '0);
                end else begin
                    // start has priority, so mt writes only land here.
                    if (bus.mthi) hi_d = bus.mt_data;
                    if (bus.mtlo) lo_d = bus.mt_data;
                end
            end
            CALC: begin
                acc_d = is_div_q ? div_next : mul_next;
                if (cnt_q == CNT_W'(WIDTH-1)) begin
                    cnt_d   = '0;
                    state_d = FIN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            FIN: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                if (!is_div_q) begin
                    {hi_d, lo_d} = prod_fix;
                end else if (bzero_q) begin
                    hi_d = a_raw_q;
                    lo_d = DIV0_LO[WIDTH-1:0];
                end else begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            acc_q     <= '0;
            b_q       <= '0;
            a_raw_q   <= '0;
            sign_lo_q <= 1'b0;
            sign_hi_q <= 1'b0;
            bzero_q   <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_div_q  <= is_div_d;
            acc_q     <= acc_d;
            b_q       <= b_d;
            a_raw_q   <= a_raw_d;
            sign_lo_q <= sign_lo_d;
            sign_hi_q <= sign_hi_d;
            bzero_q   <= bzero_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: a vector table of operations whose
// expected HI/LO are pushed to a scoreboard and compared when done pulses,
// plus hand sequences for start-while-busy, reset abort and mthi/mtlo.
module tb_mul_div_unit;
    import mdu_pkg::*;

    localparam int W   = 32;
    localparam int LAT = W + 1;
    localparam int NV  = 14;

    logic clk = 1'b0;
    logic reset;

    mul_div_unit_if #(.WIDTH(W)) bus ();

    mul_div_unit #(.WIDTH(W), .CNT_W(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } vec_t;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int           id;
    } exp_t;

    vec_t         vecs [NV];
    exp_t         sb [$];
    exp_t         mon_e;
    int           checks   = 0;
    int           errors   = 0;
    int           done_cnt = 0;
    logic [W-1:0] cur_hi   = '0;
    logic [W-1:0] cur_lo   = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every done pulse pops one expectation.
    always @(negedge clk) begin
        if (reset === 1'b0 && bus.done === 1'b1) begin
            done_cnt++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 required no pending operation");
            end else begin
                mon_e = sb.pop_front();
                chk($sformatf("op%0d_hi", mon_e.id), bus.hi, mon_e.hi);
                chk($sformatf("op%0d_lo", mon_e.id), bus.lo, mon_e.lo);
                cur_hi = mon_e.hi;
                cur_lo = mon_e.lo;
            end
        end
    end

    // Present a request for one edge, then scramble the operand inputs.
    task automatic drive_start(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.op        = op;
        bus.operand_a = a;
        bus.operand_b = b;
        bus.start     = 1'b1;
        tick();
        bus.start     = 1'b0;
        bus.operand_a = $urandom;
        bus.operand_b = $urandom;
        bus.op        = 2'($urandom_range(0, 3));
    endtask

    // Called one step after the start edge; bounded wait for done.
    task automatic wait_done(input string name);
        int lat;
        int busy_n;
        int hold_ok;
        lat     = 0;
        busy_n  = bus.busy ? 1 : 0;
        hold_ok = 1;
        for (int n = 1; n <= 60; n++) begin
            tick();
            if (bus.done) begin
                lat = n;
                break;
            end
            if (bus.busy) busy_n++;
            if (bus.hi !== cur_hi || bus.lo !== cur_lo) hold_ok = 0;
        end
        chk({name, "_latency"}, 32'(lat), 32'(LAT));
        chk({name, "_busy_cycles"}, 32'(busy_n), 32'(LAT));
        chk({name, "_hilo_held"}, 32'(hold_ok), 32'd1);
        chk({name, "_busy_at_done"}, 32'(bus.busy), 32'd0);
        tick();
        chk({name, "_done_pulse"}, 32'(bus.done), 32'd0);
    endtask

    initial begin
        int base;
        int lat;

        vecs[0]  = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[1]  = '{OP_MULT,  32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
        vecs[2]  = '{OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3]  = '{OP_DIVU,  32'd100,       32'd0,         32'h0000_0064, 32'hFFFF_FFFF};
        vecs[4]  = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vecs[5]  = '{OP_MULTU, 32'd6,         32'd7,         32'h0000_0000, 32'd42};
        vecs[6]  = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        vecs[7]  = '{OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14};
        vecs[8]  = '{OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
        vecs[9]  = '{OP_DIV,   32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd3};
        vecs[10] = '{OP_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'd1};
        vecs[11] = '{OP_DIVU,  32'hFFFF_FFFF, 32'd1,         32'h0000_0000, 32'hFFFF_FFFF};
        vecs[12] = '{OP_DIV,   32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF};
        vecs[13] = '{OP_MULTU, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780};

        bus.start     = 1'b0;
        bus.op        = OP_MULTU;
        bus.operand_a = '0;
        bus.operand_b = '0;
        bus.mthi      = 1'b0;
        bus.mtlo      = 1'b0;
        bus.mt_data   = '0;

        // Reset state
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_hi", bus.hi, 32'd0);
        chk("rst_lo", bus.lo, 32'd0);

        // Vector table
        for (int i = 0; i < NV; i++) begin
            drive_start(vecs[i].op, vecs[i].a, vecs[i].b);
            sb.push_back('{hi: vecs[i].hi, lo: vecs[i].lo, id: i});
            wait_done($sformatf("vec%0d", i));
        end

        // Start while busy and mthi during CALC are both ignored
        base = done_cnt;
        lat  = 0;
        drive_start(OP_DIVU, 32'd100, 32'd7);
        sb.push_back('{hi: 32'd2, lo: 32'd14, id: 100});
        for (int n = 1; n <= 60; n++) begin
            if (n == 5) begin
                bus.op = OP_DIVU; bus.operand_a = 32'd1; bus.operand_b = 32'd1; bus.start = 1'b1;
            end
            if (n == 6) begin
                bus.start = 1'b0; bus.mthi = 1'b1; bus.mt_data = 32'h0000_DEAD;
            end
            if (n == 7) bus.mthi = 1'b0;
            tick();
            if (bus.done && lat == 0) lat = n;
        end
        chk("busy_start_latency", 32'(lat), 32'(LAT));
        chk("busy_start_done_count", 32'(done_cnt - base), 32'd1);
        chk("busy_start_hi_final", bus.hi, 32'd2);

        // Reset mid-operation aborts without a done pulse
        drive_start(OP_MULTU, 32'h0000_FFFF, 32'h0000_FFFF);
        base = done_cnt;
        for (int n = 1; n <= 9; n++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        cur_hi = '0;
        cur_lo = '0;
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_hi", bus.hi, 32'd0);
        chk("abort_lo", bus.lo, 32'd0);
        for (int n = 0; n < 40; n++) tick();
        chk("abort_no_done", 32'(done_cnt - base), 32'd0);
        drive_start(OP_MULTU, 32'd6, 32'd7);
        sb.push_back('{hi: 32'd0, lo: 32'd42, id: 200});
        wait_done("after_abort");

        // mthi / mtlo in IDLE
        bus.mtlo = 1'b1; bus.mt_data = 32'h1234_5678;
        tick();
        bus.mtlo = 1'b0;
        chk("mtlo_lo", bus.lo, 32'h1234_5678);
        chk("mtlo_hi", bus.hi, 32'd0);
        bus.mthi = 1'b1; bus.mt_data = 32'hCAFE_F00D;
        tick();
        bus.mthi = 1'b0;
        chk("mthi_hi", bus.hi, 32'hCAFE_F00D);
        chk("mthi_lo", bus.lo, 32'h1234_5678);
        bus.mthi = 1'b1; bus.mtlo = 1'b1; bus.mt_data = 32'h55AA_55AA;
        tick();
        bus.mthi = 1'b0; bus.mtlo = 1'b0;
        chk("mtboth_hi", bus.hi, 32'h55AA_55AA);
        chk("mtboth_lo", bus.lo, 32'h55AA_55AA);
        cur_hi = 32'h55AA_55AA;
        cur_lo = 32'h55AA_55AA;

        // start together with mtlo: the write is dropped
        bus.mtlo = 1'b1; bus.mt_data = 32'h0000_0BAD;
        drive_start(OP_MULTU, 32'd3, 32'd5);
        bus.mtlo = 1'b0;
        chk("start_mt_lo_kept", bus.lo, 32'h55AA_55AA);
        chk("start_mt_busy", 32'(bus.busy), 32'd1);
        sb.push_back('{hi: 32'd0, lo: 32'd15, id: 300});
        wait_done("start_mt");

        tick();
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
